spi_tx_sequencer: RTL and testbench

// - Upstream feeder for the SPI master transmitter: buffers 16-bit words from a host-side write port in a small FIFO.
// - Presents one word at a time on the transmitter's data_in and pulses strt to launch each transaction.
// - Tracks CS to detect the end of each transaction, counts completed words, and flags a transmitter that never asserts CS.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_tx_fifo.sv | 39 +++
 rtl/spi_tx_sequencer.sv | 85 ++++++++
 tb/tb_spi_tx_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared widths and sequencer state encoding for the SPI transmit feeder
package spi_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_GAP = 3'd5;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    START = ST_START,
    WAIT_LO = ST_WAIT_LO,
    WAIT_HI = ST_WAIT_HI,
    GAP = ST_GAP
  } state_t;
endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous word FIFO with wrap-bit pointers and occupancy flags
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WORD_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [WORD_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: feeds buffered words to the SPI transmitter and tracks each CS transaction
module spi_tx_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STRT_CYCLES = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic                   clr_err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WORD_W-1:0]      data_in,
  output logic                   strt,
  input  logic                   CS,
  output logic                   busy,
  output logic [CNT_W-1:0]       sent_cnt,
  output logic                   timeout_err
);
  localparam int TMAX0 = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
  localparam int TMAX = TMAX0 > STRT_CYCLES ? TMAX0 : STRT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  state_t state, state_nxt;
  logic [TW-1:0] timer;
  logic [WORD_W-1:0] head;
  logic pop, to_fire, sent_inc;
  spi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign strt = state == START;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    to_fire = 1'b0;
    sent_inc = 1'b0;
    case (state)
      IDLE: state_nxt = empty ? IDLE : LOAD;
      LOAD: begin
        pop = 1'b1;
        state_nxt = START;
      end
      START: state_nxt = timer == TW'(STRT_CYCLES - 1) ? WAIT_LO : START;
      WAIT_LO: begin
        to_fire = CS && timer == TW'(TIMEOUT - 1);
        state_nxt = !CS ? WAIT_HI : to_fire ? GAP : WAIT_LO;
      end
      WAIT_HI: begin
        sent_inc = CS;
        state_nxt = CS ? GAP : WAIT_HI;
      end
      GAP: state_nxt = timer == TW'(GAP_CYCLES - 1) ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end
  // timer restarts on every state change so each state measures its own dwell
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      data_in <= '0;
      sent_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= state_nxt != state ? '0 : timer + 1'b1;
      if (pop) data_in <= head;
      if (sent_inc) sent_cnt <= sent_cnt + 1'b1;
      timeout_err <= to_fire | (timeout_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb_spi_tx_sequencer: directed checks of launch timing, FIFO limits, timeout, reset and count wrap
module tb_spi_tx_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic clr_err = 1'b0;
  logic cs = 1'b1;
  logic full, empty, strt, busy, timeout_err;
  logic [2:0] count;
  logic [15:0] data_in;
  logic [7:0] sent_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  spi_tx_sequencer dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clr_err(clr_err),
    .full(full),
    .empty(empty),
    .count(count),
    .data_in(data_in),
    .strt(strt),
    .CS(cs),
    .busy(busy),
    .sent_cnt(sent_cnt),
    .timeout_err(timeout_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic wait_strt(input string tag);
    int n = 0;
    while (!strt && n < 100) begin
      tick();
      n++;
    end
    chk(tag, strt, 1);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask
  // emulate the transmitter: CS low for three cycles once strt has finished
  task automatic xact(input logic [15:0] exp, input bit full_chk);
    wait_strt("xact_strt");
    if (full_chk) chk("xact_data_start", data_in, exp);
    tick();
    if (full_chk) chk("xact_strt_2nd", strt, 1);
    tick();
    if (full_chk) chk("xact_strt_off", strt, 0);
    cs = 1'b0;
    tick();
    tick();
    tick();
    if (full_chk) chk("xact_data_cs_low", data_in, exp);
    cs = 1'b1;
    tick();
    wait_idle("xact_idle");
  endtask
  initial begin
    tick();
    tick();
    chk("rst_data_in", data_in, 0);
    chk("rst_strt", strt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    rst = 1'b1;
    tick();
    push(16'h5555);
    chk("single_count", count, 1);
    chk("single_busy_n", busy, 0);
    chk("single_strt_n", strt, 0);
    tick();
    chk("single_load_busy", busy, 1);
    chk("single_load_strt", strt, 0);
    tick();
    chk("single_strt_n2", strt, 1);
    chk("single_data", data_in, 16'h5555);
    chk("single_empty", empty, 1);
    tick();
    chk("single_strt_n3", strt, 1);
    tick();
    chk("single_strt_n4", strt, 0);
    chk("single_wait_busy", busy, 1);
    cs = 1'b0;
    tick();
    tick();
    chk("single_data_cs", data_in, 16'h5555);
    chk("single_sent_pre", sent_cnt, 0);
    cs = 1'b1;
    tick();
    chk("single_sent", sent_cnt, 1);
    tick();
    tick();
    tick();
    chk("single_gap_busy", busy, 1);
    tick();
    chk("single_idle", busy, 0);
    push(16'h1111);
    wait_strt("burst_lead_strt");
    tick();
    tick();
    push(16'hA001);
    push(16'hA002);
    push(16'hA003);
    chk("burst_full_n", full, 0);
    push(16'hA004);
    chk("burst_full", full, 1);
    chk("burst_count4", count, 4);
    push(16'hA005);
    chk("burst_drop_count", count, 4);
    cs = 1'b0;
    tick();
    cs = 1'b1;
    tick();
    wait_idle("burst_lead_idle");
    chk("burst_lead_sent", sent_cnt, 2);
    xact(16'hA001, 1'b1);
    xact(16'hA002, 1'b1);
    xact(16'hA003, 1'b1);
    xact(16'hA004, 1'b1);
    chk("burst_sent", sent_cnt, 6);
    chk("burst_empty", empty, 1);
    chk("burst_data_last", data_in, 16'hA004);
    push(16'h0F0F);
    wait_strt("to_strt");
    tick();
    tick();
    for (int i = 0; i < 63; i++) tick();
    chk("to_before", timeout_err, 0);
    tick();
    chk("to_fire", timeout_err, 1);
    chk("to_sent", sent_cnt, 6);
    tick();
    chk("to_sticky", timeout_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_clear", timeout_err, 0);
    wait_idle("to_idle");
    push(16'h0F0F);
    wait_strt("sim_strt");
    tick();
    tick();
    for (int i = 0; i < 63; i++) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sim_set_wins", timeout_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sim_clear", timeout_err, 0);
    wait_idle("sim_idle");
    push(16'h7777);
    wait_strt("mid_strt");
    tick();
    tick();
    cs = 1'b0;
    tick();
    push(16'h8888);
    chk("mid_count", count, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cs = 1'b1;
    chk("mid_strt", strt, 0);
    chk("mid_data", data_in, 0);
    chk("mid_empty", empty, 1);
    chk("mid_count0", count, 0);
    chk("mid_sent", sent_cnt, 0);
    chk("mid_busy", busy, 0);
    tick();
    chk("mid_stay_idle", busy, 0);
    for (int i = 0; i < 256; i++) begin
      push(16'(i));
      xact(16'(i), 1'b0);
      if (i == 254) chk("wrap_255", sent_cnt, 255);
    end
    chk("wrap_zero", sent_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
